// File: rtl/fp_pkg.sv
// Shared single-precision field widths, constants and operand/result types
// for the FP add/sub leaf.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_op_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] out_mant;
    logic              totalcarry;
    logic [MANT_W-1:0] sss;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  res;
  } fp_res_t;

  // Zero exponent flushes the operand to zero regardless of fraction.
  function automatic fp_op_t unpack_op(logic s, logic [EXP_W-1:0] e, logic [FRAC_W-1:0] f);
    fp_op_t o;
    o.sign = s;
    o.exp  = e;
    o.mant = (e == '0) ? '0 : {1'b1, f};
    return o;
  endfunction
endpackage

// File: rtl/fp_add_sub_if.sv
// Operand/result bundle of the FP add/sub leaf; master drives operands,
// slave (the adder) drives results.
interface fp_add_sub_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              sa;
  logic              sb;
  logic              opcode;
  logic [FRAC_W-1:0] ma;
  logic [FRAC_W-1:0] mb;
  logic [EXP_W-1:0]  ea;
  logic [EXP_W-1:0]  eb;

  logic              out_valid;
  logic [MANT_W-1:0] out_mant;
  logic              sign;
  logic [EXP_W-1:0]  exponent;
  logic              totalcarry;
  logic [31:0]       sum2;
  logic [MANT_W-1:0] sss;
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  res;

  modport master (
    output in_valid, sa, sb, opcode, ma, mb, ea, eb,
    input  out_valid, out_mant, sign, exponent, totalcarry, sum2, sss, mant, res
  );

  modport slave (
    input  in_valid, sa, sb, opcode, ma, mb, ea, eb,
    output out_valid, out_mant, sign, exponent, totalcarry, sum2, sss, mant, res
  );
endinterface

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; returns 24 for an all-zero input.
module fp_lzc24
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] d,
  output logic [4:0]        cnt
);
  // Scan upward so the highest set bit is the last to write cnt.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < MANT_W; i++)
      if (d[i]) cnt = 5'(MANT_W - 1 - i);
  end
endmodule

// File: rtl/fp_add_sub.sv
// Single-precision add/sub with one registered output stage and exposed
// alignment/carry debug values. Define FP_SPECIAL_EN to decode Inf/NaN inputs.
module fp_add_sub
  import fp_pkg::*;
(
  input logic         clk,
  input logic         rst,
  fp_add_sub_if.slave bus
);
  fp_op_t                  op_a, op_b, op_l, op_s;
  logic                    a_big, same_sgn;
  logic [EXP_W-1:0]        ediff;
  logic [MANT_W-1:0]       aligned, diff, r_mant;
  logic [MANT_W:0]         sum25;
  logic [4:0]              lz;
  logic signed [EXP_W+1:0] e_norm;
  logic                    r_zero;
  fp_res_t                 nxt, q;
  logic                    vld_q;

  // Order by exponent then mantissa; a full tie keeps A as the larger.
  always_comb begin
    op_a     = unpack_op(bus.sa, bus.ea, bus.ma);
    op_b     = unpack_op(bus.sb ^ bus.opcode, bus.eb, bus.mb);
    a_big    = {op_a.exp, op_a.mant} >= {op_b.exp, op_b.mant};
    op_l     = a_big ? op_a : op_b;
    op_s     = a_big ? op_b : op_a;
    ediff    = op_l.exp - op_s.exp;
    aligned  = (ediff >= 8'd24) ? '0 : (op_s.mant >> ediff);
    same_sgn = (op_a.sign == op_b.sign);
    sum25    = {1'b0, op_l.mant} + {1'b0, aligned};
    diff     = op_l.mant - aligned;
  end

  fp_lzc24 u_lzc (
    .d   (diff),
    .cnt (lz)
  );

  always_comb begin
    nxt      = '0;
    nxt.mant = op_l.mant;
    nxt.sss  = aligned;
    nxt.res  = ediff;
    if (same_sgn) begin
      nxt.totalcarry = sum25[MANT_W];
      e_norm = $signed({2'b00, op_l.exp}) + (sum25[MANT_W] ? 10'sd1 : 10'sd0);
      r_mant = sum25[MANT_W] ? sum25[MANT_W:1] : sum25[MANT_W-1:0];
      r_zero = (sum25 == '0);
    end else begin
      e_norm = $signed({2'b00, op_l.exp}) - $signed({5'b00000, lz});
      r_mant = diff << lz;
      r_zero = (diff == '0) || (e_norm <= 10'sd0);
    end

    if (r_zero) begin
      // Only -0 + -0 (same effective signs, both zero) keeps a negative sign.
      nxt.sign = same_sgn & op_l.sign;
    end else if (e_norm > 10'sd254) begin
      nxt.sign     = op_l.sign;
      nxt.exponent = EXP_MAX;
      nxt.out_mant = {1'b1, {FRAC_W{1'b0}}};
    end else begin
      nxt.sign     = op_l.sign;
      nxt.exponent = e_norm[EXP_W-1:0];
      nxt.out_mant = r_mant;
    end

`ifdef FP_SPECIAL_EN
    begin
      logic a_nan, b_nan, a_inf, b_inf;
      a_nan = (bus.ea == EXP_MAX) && (bus.ma != '0);
      b_nan = (bus.eb == EXP_MAX) && (bus.mb != '0);
      a_inf = (bus.ea == EXP_MAX) && (bus.ma == '0);
      b_inf = (bus.eb == EXP_MAX) && (bus.mb == '0);
      if (a_nan || b_nan || (a_inf && b_inf && (op_a.sign != op_b.sign))) begin
        nxt = '0;
        {nxt.sign, nxt.exponent, nxt.out_mant[FRAC_W-1:0]} = QNAN;
        nxt.out_mant[FRAC_W] = 1'b1;
      end else if (a_inf || b_inf) begin
        nxt          = '0;
        nxt.sign     = a_inf ? op_a.sign : op_b.sign;
        nxt.exponent = EXP_MAX;
        nxt.out_mant = {1'b1, {FRAC_W{1'b0}}};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) q <= nxt;
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.out_mant   = q.out_mant;
  assign bus.sign       = q.sign;
  assign bus.exponent   = q.exponent;
  assign bus.totalcarry = q.totalcarry;
  assign bus.sum2       = {q.sign, q.exponent, q.out_mant[FRAC_W-1:0]};
  assign bus.sss        = q.sss;
  assign bus.mant       = q.mant;
  assign bus.res        = q.res;
endmodule

// File: tb/tb_fp_add_sub.sv
// Randomized and directed bench for fp_add_sub against an integer-arithmetic
// reference of the add/sub rules.
module tb_fp_add_sub;
  typedef struct packed {
    logic [31:0] sum2;
    logic [23:0] out_mant;
    logic        sign;
    logic [7:0]  exponent;
    logic        tc;
    logic [23:0] sss;
    logic [23:0] mant;
    logic [7:0]  res;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  exp_t last;

  fp_add_sub_if bus ();

  fp_add_sub dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Exact sign-magnitude arithmetic on integer mantissas, then loop normalization.
  function automatic exp_t model(logic a_s, logic b_s, logic opc, logic [22:0] fa,
                                 logic [22:0] fb, logic [7:0] xa, logic [7:0] xb);
    exp_t   r;
    longint va, vb, ml, ms, al, sum, mag;
    int     el, ex;
    logic   sbe, sl, ss;
    r   = '0;
    sbe = b_s ^ opc;
`ifdef FP_SPECIAL_EN
    if (xa == 8'hFF || xb == 8'hFF) begin
      logic an, bn, ai, bi;
      an = (xa == 8'hFF) && (fa != 0);
      bn = (xb == 8'hFF) && (fb != 0);
      ai = (xa == 8'hFF) && (fa == 0);
      bi = (xb == 8'hFF) && (fb == 0);
      if (an || bn || (ai && bi && (a_s != sbe))) begin
        r.exponent = 8'hFF;
        r.out_mant = 24'hC00000;
      end else begin
        r.sign     = ai ? a_s : sbe;
        r.exponent = 8'hFF;
        r.out_mant = 24'h800000;
      end
      r.sum2 = {r.sign, r.exponent, r.out_mant[22:0]};
      return r;
    end
`endif
    va = (xa == 0) ? 0 : ((longint'(1) << 23) + longint'(fa));
    vb = (xb == 0) ? 0 : ((longint'(1) << 23) + longint'(fb));
    if (longint'(xa) * (longint'(1) << 24) + va >= longint'(xb) * (longint'(1) << 24) + vb) begin
      ml = va; ms = vb; el = int'(xa); sl = a_s; ss = sbe;
    end else begin
      ml = vb; ms = va; el = int'(xb); sl = sbe; ss = a_s;
    end
    r.res  = (xa > xb) ? xa - xb : xb - xa;
    al     = (r.res >= 24) ? 0 : (ms >> r.res);
    r.mant = 24'(ml);
    r.sss  = 24'(al);
    r.tc   = (sl == ss) && (ml + al >= (longint'(1) << 24));
    sum    = (sl ? -ml : ml) + (ss ? -al : al);
    if (sum == 0) begin
      r.sign = (xa == 0) && (xb == 0) && a_s && sbe;
    end else begin
      mag = (sum < 0) ? -sum : sum;
      ex  = el;
      while (mag >= (longint'(1) << 24)) begin mag = mag >> 1; ex++; end
      while (mag < (longint'(1) << 23)) begin mag = mag << 1; ex--; end
      if (ex > 254) begin
        r.sign = (sum < 0); r.exponent = 8'hFF; r.out_mant = 24'h800000;
      end else if (ex > 0) begin
        r.sign = (sum < 0); r.exponent = 8'(ex); r.out_mant = 24'(mag);
      end
    end
    r.sum2 = {r.sign, r.exponent, r.out_mant[22:0]};
    return r;
  endfunction

  task automatic check_out(input string tag, input exp_t e, input logic vld);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
    chk({tag, ".sum2"},      bus.sum2, e.sum2);
    chk({tag, ".out_mant"},  32'(bus.out_mant), 32'(e.out_mant));
    chk({tag, ".sign"},      32'(bus.sign), 32'(e.sign));
    chk({tag, ".exponent"},  32'(bus.exponent), 32'(e.exponent));
    chk({tag, ".totalcarry"}, 32'(bus.totalcarry), 32'(e.tc));
    chk({tag, ".sss"},       32'(bus.sss), 32'(e.sss));
    chk({tag, ".mant"},      32'(bus.mant), 32'(e.mant));
    chk({tag, ".res"},       32'(bus.res), 32'(e.res));
  endtask

  task automatic drive(input logic a_s, input logic b_s, input logic opc, input logic [22:0] fa,
                       input logic [22:0] fb, input logic [7:0] xa, input logic [7:0] xb);
    bus.sa = a_s; bus.sb = b_s; bus.opcode = opc;
    bus.ma = fa;  bus.mb = fb;  bus.ea = xa; bus.eb = xb;
  endtask

  task automatic run_op(input string tag, input logic a_s, input logic b_s, input logic opc,
                        input logic [22:0] fa, input logic [22:0] fb,
                        input logic [7:0] xa, input logic [7:0] xb);
    drive(a_s, b_s, opc, fa, fb, xa, xb);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    last = model(a_s, b_s, opc, fa, fb, xa, xb);
    check_out(tag, last, 1'b1);
  endtask

  initial begin
    logic [7:0]  xa, xb;
    logic [22:0] fa, fb;
    n_chk = 0; n_err = 0;
    clk = 0; rst = 1;
    bus.in_valid = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", '0, 1'b0);
    rst = 0;

    // Directed cases with hand-derived expectations
    run_op("tp1", 1, 0, 1, 23'h400000, 23'h400000, 8'd1, 8'd1);
    chk("tp1.mant_k", 32'(bus.mant), 32'h00C00000);
    chk("tp1.sss_k", 32'(bus.sss), 32'h00C00000);
    chk("tp1.res_k", 32'(bus.res), 32'd0);
    chk("tp1.tc_k", 32'(bus.totalcarry), 32'd1);
    chk("tp1.exp_k", 32'(bus.exponent), 32'd2);
    chk("tp1.sum2_k", bus.sum2, 32'h81400000);
    run_op("one_plus_one", 0, 0, 0, 23'h0, 23'h0, 8'd127, 8'd127);
    chk("one_plus_one.sum2_k", bus.sum2, 32'h40000000);
    chk("one_plus_one.tc_k", 32'(bus.totalcarry), 32'd1);
    run_op("three_minus_one", 0, 0, 1, 23'h400000, 23'h0, 8'd128, 8'd127);
    chk("three_minus_one.sum2_k", bus.sum2, 32'h40000000);
    chk("three_minus_one.res_k", 32'(bus.res), 32'd1);
    chk("three_minus_one.tc_k", 32'(bus.totalcarry), 32'd0);
    run_op("cancel", 0, 0, 1, 23'h400000, 23'h400000, 8'd127, 8'd127);
    chk("cancel.sum2_k", bus.sum2, 32'h00000000);
    chk("cancel.sign_k", 32'(bus.sign), 32'd0);
    run_op("shift_out", 0, 0, 0, 23'h0, 23'h0, 8'd127, 8'd97);
    chk("shift_out.res_k", 32'(bus.res), 32'd30);
    chk("shift_out.sss_k", 32'(bus.sss), 32'd0);
    chk("shift_out.sum2_k", bus.sum2, 32'h3F800000);
    run_op("neg_zeros", 1, 0, 1, 23'h12345, 23'h0, 8'd0, 8'd0);
    chk("neg_zeros.sum2_k", bus.sum2, 32'h80000000);
    run_op("mixed_zeros", 1, 0, 0, 23'h0, 23'h0, 8'd0, 8'd0);
    chk("mixed_zeros.sum2_k", bus.sum2, 32'h00000000);
    run_op("overflow", 0, 0, 0, 23'h7FFFFF, 23'h7FFFFF, 8'd254, 8'd254);
    chk("overflow.sum2_k", bus.sum2, 32'h7F800000);
    run_op("underflow", 0, 0, 1, 23'h000001, 23'h000000, 8'd1, 8'd1);
    chk("underflow.sum2_k", bus.sum2, 32'h00000000);
    run_op("sub_norm", 0, 1, 0, 23'h000001, 23'h000000, 8'd130, 8'd130);

    // Outputs hold while in_valid is low even if operands change
    drive(1, 1, 1, 23'h7ABCDE, 23'h012345, 8'd200, 8'd3);
    @(posedge clk); #1;
    check_out("hold", last, 1'b0);

    // Reset asserted mid-stream with a valid operation presented
    drive(0, 0, 0, 23'h111111, 23'h222222, 8'd140, 8'd138);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    check_out("mid_reset", '0, 1'b0);
    run_op("after_reset", 0, 1, 1, 23'h200000, 23'h600000, 8'd100, 8'd99);

    for (int n = 0; n < 400; n++) begin
      xa = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: xb = 8'($urandom_range(0, 255));
        1: xb = xa;
        2: xb = 8'(32'(xa) + $urandom_range(0, 30) - 32'd15);
        default: xb = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'd255;
      endcase
      fa = 23'($urandom);
      fb = ($urandom_range(0, 3) == 0) ? fa : 23'($urandom);
      run_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), fa, fb, xa, xb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fp_add_sub.md
Name: fp_add_sub

Overview:
- Single-precision (IEEE-754 layout) floating-point adder/subtractor with one registered output stage.
- Operands arrive as separate sign, exponent and mantissa fields.
- Produces the packed 32-bit result plus intermediate datapath values (alignment, carry, exponent difference) for debug and verification.
- Sits in the arithmetic unit as the FP add/sub leaf.

Parameters:
- None. The format is fixed at 1/8/23.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid this cycle
- sa  in  1  sign of A
- sb  in  1  sign of B
- opcode  in  1  0 = A+B, 1 = A-B
- ma  in  23  fraction of A
- mb  in  23  fraction of B
- ea  in  8  biased exponent of A
- eb  in  8  biased exponent of B
- out_valid  out  1  result valid
- out_mant  out  24  normalized result mantissa, hidden bit included
- sign  out  1  result sign
- exponent  out  8  result biased exponent
- totalcarry  out  1  carry-out of the 24-bit magnitude addition
- sum2  out  32  packed result {sign, exponent, out_mant[22:0]}
- sss  out  24  aligned (right-shifted) smaller-magnitude mantissa
- mant  out  24  larger-magnitude mantissa {1, frac}
- res  out  8  absolute exponent difference

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high; it clears all outputs and out_valid to 0.
- Latency: one cycle. Datapath is combinational from the inputs; all outputs register on a clk edge where in_valid=1.
- out_valid is in_valid delayed by one cycle. When in_valid=0, outputs hold their previous values.
- Operand preparation:
  - Effective sign of B is sb XOR opcode.
  - A hidden bit of 1 is prepended when the exponent is non-zero.
  - Exponent 0 means the operand is zero (denormals flushed; fraction ignored).
- Ordering: larger magnitude is decided by exponent, then mantissa. On a full tie, A is taken as larger.
- Alignment:
  - res = |ea-eb|.
  - sss = smaller mantissa >> res; res >= 24 gives sss = 0.
  - Shifted-out bits are discarded (truncation; no guard/round/sticky).
- Same effective signs: 25-bit sum = mant + sss, and totalcarry = bit 24.
  - If carry: out_mant = sum[24:1] and exponent = larger exponent + 1.
- Different effective signs: diff = mant - sss, and totalcarry = 0.
  - Normalize by left shift of the leading-zero count; exponent = larger exponent - count.
  - If the exponent would go <= 0, the result flushes to +0.
- Sign is the effective sign of the larger operand.
- Exact zero result (including full cancellation): sign = 0, exponent = 0, out_mant = 0.
- Both operands zero: result is +0, except -0 + -0, which gives -0.
- Exponent overflow (result exponent > 254): exponent = 255, out_mant[22:0] = 0, i.e. infinity.

Optional Feature:
- Macro: FP_SPECIAL_EN.
- Defined:
  - An input exponent of 255 is decoded as Inf/NaN.
  - NaN in, or Inf-Inf with opposite effective signs, gives quiet NaN 0x7FC00000.
  - Inf op finite gives a correctly signed Inf.
  - Debug outputs (mant, sss, res, totalcarry) are 0 in these cases.
- Undefined: exponent 255 is treated as an ordinary value; only the overflow-to-infinity rule applies.

Decomposition:
- Shared package fp_pkg:
  - Field widths: EXP_W=8, FRAC_W=23, MANT_W=24.
  - Constants: EXP_MAX=8'hFF, QNAN=32'h7FC00000.
  - Typedef for the unpacked operand struct {sign, exp, mant}.
- One sub-module, fp_lzc24: combinational 24-bit leading-zero counter, 5-bit output, 24 when input is zero.

Test Plan:
- sa=1, sb=0, opcode=1, ma=mb=23'h400000, ea=eb=1 -> after 1 clk:
  - mant=24'hC00000, sss=24'hC00000, res=0, totalcarry=1
  - out_mant=24'hC00000, exponent=2, sign=1, sum2=32'h81400000
- 1.0+1.0 (sa=sb=0, opcode=0, ea=eb=127, ma=mb=0) -> sum2=32'h40000000, totalcarry=1.
- 3.0-1.0 (ea=128, ma=23'h400000; eb=127, mb=0; opcode=1) -> sum2=32'h40000000, res=1, totalcarry=0.
- 1.5-1.5 (equal operands, opcode=1) -> sum2=32'h00000000, sign=0.
- Alignment shift-out: ea=127, eb=97, ma=mb=0, opcode=0 -> res=30, sss=0, sum2=32'h3F800000.
- Assert rst with in_valid=1 mid-stream -> all outputs and out_valid are 0 on the next edge; a fresh operation after release yields its correct result one cycle later.
